logic_seq: RTL
==============

LOGIC_SEQ -- requirements
Module: logic_seq

Interface
REQ-001 Parameter DELAY_RISE, default 0: rise delay passed through to any gate-level cells instantiated inside the block.
REQ-002 Parameter DELAY_FALL, default 0: fall delay passed through to any gate-level cells instantiated inside the block.
REQ-003 Parameter SETTLE_CYCLES, default 1, legal range 1..15: cycles allowed for the downstream logic-op datapath to settle before the result is captured.
REQ-004 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-005 RST_BAR  input  1  reset; synchronous, active-low.
REQ-006 START  input  1  request to begin an operation; sampled only in IDLE.
REQ-007 OP_IN  input  4  truth-table select for the requested operation.
REQ-008 BUS_IN  input  8  operand data bus.
REQ-009 BUS_VALID  input  1  BUS_IN holds a valid operand.
REQ-010 BUS_READY  output  1  block accepts an operand this cycle.
REQ-011 OP_SEL_OUT  output  4  registered truth-table select, driven to the logic-op stage.
REQ-012 LHS_OUT  output  8  registered left operand, driven to the logic-op stage.
REQ-013 RHS_OUT  output  8  registered right operand, driven to the logic-op stage.
REQ-014 RESULT_IN  input  8  combinational result returned from the logic-op stage.
REQ-015 RESULT_OUT  output  8  captured result.
REQ-016 Z_FLAG  output  1  captured result equals 8'h00.
REQ-017 N_FLAG  output  1  bit 7 of the captured result.
REQ-018 BUSY  output  1  operation in progress.
REQ-019 DONE  output  1  one-cycle completion strobe.

Function
REQ-020 FSM states SHALL be IDLE, LHS, RHS, SETTLE and FIN, all outputs registered or decoded from state only.
REQ-021 In IDLE, START=1 at an edge SHALL latch OP_IN into OP_SEL_OUT and move to LHS; START=0 SHALL leave the block in IDLE.
REQ-022 BUS_READY SHALL be 1 exactly in LHS and RHS and 0 in all other states.
REQ-023 In LHS, an edge with BUS_VALID=1 SHALL load BUS_IN into LHS_OUT and move to RHS; BUS_VALID=0 SHALL hold state and all registers.
REQ-024 In RHS, an edge with BUS_VALID=1 SHALL load BUS_IN into RHS_OUT, load the settle counter with SETTLE_CYCLES-1 and move to SETTLE; BUS_VALID=0 SHALL hold.
REQ-025 In SETTLE, the counter SHALL decrement each edge while nonzero; at the edge where it equals 0, the block SHALL capture RESULT_IN into RESULT_OUT, Z_FLAG and N_FLAG and move to FIN, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-026 FIN SHALL last exactly one cycle with DONE=1, then return to IDLE unconditionally.
REQ-027 DONE SHALL be 0 in every state except FIN.
REQ-028 BUSY SHALL be 1 in LHS, RHS and SETTLE and 0 in IDLE and FIN.
REQ-029 START SHALL be ignored outside IDLE, including during FIN; OP_IN changes after acceptance SHALL NOT affect OP_SEL_OUT.
REQ-030 OP_SEL_OUT, LHS_OUT and RHS_OUT SHALL remain stable from their load until the next accepted START, and through FIN and IDLE.
REQ-031 RESULT_OUT and the flags SHALL change only at the capture edge of REQ-025 or on reset.
REQ-032 With BUS_VALID held at 1, START accepted at edge n SHALL give DONE=1 in the cycle after edge n+2+SETTLE_CYCLES.

Reset
REQ-033 An edge with RST_BAR=0 SHALL force IDLE, clear the settle counter and drive OP_SEL_OUT=4'h0, LHS_OUT=8'h00, RHS_OUT=8'h00, RESULT_OUT=8'h00, Z_FLAG=0, N_FLAG=0, BUSY=0, DONE=0 and BUS_READY=0.
REQ-034 Reset SHALL take priority over every other input in any state; an operation interrupted mid-way SHALL NOT produce DONE or a capture.

Verification
REQ-035 SETTLE_CYCLES=1, BUS_VALID=1, START with OP_IN=4'b1000, bus 8'hF0 then 8'h3C -> RESULT_OUT=8'h30, Z=0, N=0, DONE high for one cycle, 4 cycles after the START edge.
REQ-036 OP_IN=4'b0110, operands 8'h5A and 8'h5A -> RESULT_OUT=8'h00, Z=1, N=0.
REQ-037 SETTLE_CYCLES=3, OP_IN=4'b1110, operands 8'h80 and 8'h01, BUS_VALID low for 2 cycles before each operand -> BUS_READY holds at 1 while stalled; RESULT_OUT=8'h81, N=1; SETTLE spans 3 cycles.
REQ-038 START pulsed in LHS, SETTLE and FIN with a different OP_IN -> no effect on state or OP_SEL_OUT; a START in the following IDLE cycle is accepted.
REQ-039 RST_BAR=0 for one edge while in SETTLE -> next cycle IDLE, all outputs at their REQ-033 values, no DONE pulse.

Source files
------------

// File: rtl/logic_seq.sv
// Sequencer for an external logic-op stage: it takes a truth-table select and two
// operands, waits a fixed settle time, then captures the result and its flags.
module logic_seq #(
  parameter int DELAY_RISE    = 0,
  parameter int DELAY_FALL    = 0,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST_BAR,
  input  logic       START,
  input  logic [3:0] OP_IN,
  input  logic [7:0] BUS_IN,
  input  logic       BUS_VALID,
  output logic       BUS_READY,
  output logic [3:0] OP_SEL_OUT,
  output logic [7:0] LHS_OUT,
  output logic [7:0] RHS_OUT,
  input  logic [7:0] RESULT_IN,
  output logic [7:0] RESULT_OUT,
  output logic       Z_FLAG,
  output logic       N_FLAG,
  output logic       BUSY,
  output logic       DONE
);

  // No gate-level cells exist in this RTL, so the delays have nowhere to go.
  // An empty marker block appears in the hierarchy when a parameter is out of range.
  if (DELAY_RISE < 0 || DELAY_FALL < 0 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_param_range_error
  end

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LHS, RHS, SETTLE, FIN} state_t;

  state_t     r_state, w_nxt;
  logic [3:0] r_cnt;
  logic [3:0] r_op;
  logic [7:0] r_lhs, r_rhs, r_res;
  logic       r_z, r_n;
  logic       w_ld_op, w_ld_lhs, w_ld_rhs, w_dec, w_cap;

  always_ff @(posedge CLK) begin
    if (!RST_BAR) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_ld_op  = 1'b0;
    w_ld_lhs = 1'b0;
    w_ld_rhs = 1'b0;
    w_dec    = 1'b0;
    w_cap    = 1'b0;
    unique case (r_state)
      IDLE: if (START) begin
        w_ld_op = 1'b1;
        w_nxt   = LHS;
      end
      LHS: if (BUS_VALID) begin
        w_ld_lhs = 1'b1;
        w_nxt    = RHS;
      end
      RHS: if (BUS_VALID) begin
        w_ld_rhs = 1'b1;
        w_nxt    = SETTLE;
      end
      SETTLE: if (r_cnt == 4'd0) begin
        w_cap = 1'b1;
        w_nxt = FIN;
      end else begin
        w_dec = 1'b1;
      end
      FIN:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Operand/result registers only move on their load strobes, so they hold through FIN and IDLE.
  always_ff @(posedge CLK) begin
    if (!RST_BAR) begin
      r_cnt <= 4'd0;
      r_op  <= 4'h0;
      r_lhs <= 8'h00;
      r_rhs <= 8'h00;
      r_res <= 8'h00;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
    end else begin
      if (w_ld_op)  r_op  <= OP_IN;
      if (w_ld_lhs) r_lhs <= BUS_IN;
      if (w_ld_rhs) begin
        r_rhs <= BUS_IN;
        r_cnt <= CNT_LOAD;
      end
      if (w_dec) r_cnt <= r_cnt - 4'd1;
      if (w_cap) begin
        r_res <= RESULT_IN;
        r_z   <= (RESULT_IN == 8'h00);
        r_n   <= RESULT_IN[7];
      end
    end
  end

  assign BUS_READY  = (r_state == LHS) || (r_state == RHS);
  assign BUSY       = (r_state == LHS) || (r_state == RHS) || (r_state == SETTLE);
  assign DONE       = (r_state == FIN);
  assign OP_SEL_OUT = r_op;
  assign LHS_OUT    = r_lhs;
  assign RHS_OUT    = r_rhs;
  assign RESULT_OUT = r_res;
  assign Z_FLAG     = r_z;
  assign N_FLAG     = r_n;

endmodule
